// File: rtl/fp_to_fixed_pipe_pkg.sv
// Shared definitions for the float-to-fixed pipeline: operand classes, rounding modes,
// and the exponent bias helper.
package fp_to_fixed_pipe_pkg;

  typedef enum logic [2:0] {
    ClsZero,
    ClsSub,
    ClsNorm,
    ClsInf,
    ClsNan
  } fp_class_e;

  typedef enum logic {
    RndRne = 1'b0,
    RndRtz = 1'b1
  } rnd_mode_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_to_fixed_pipe_if.sv
// Operand/result stream bundle for fp_to_fixed_pipe; slave is the converter side.
interface fp_to_fixed_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FIX_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   a;
  logic                   rnd_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [FIX_W-1:0]       result;
  logic                   flag_ovf;
  logic                   flag_inv;
  logic                   flag_inx;

  modport master (
    output in_valid, a, rnd_mode, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_inv, flag_inx
  );

  modport slave (
    input  in_valid, a, rnd_mode, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_inv, flag_inx
  );
endinterface

// File: rtl/fp_fix_shifter.sv
// Combinational barrel shifter: scales the significand by 2^shift into a FIX_W-bit magnitude,
// returning guard/sticky for right shifts and overflow when bits fall off the top.
module fp_fix_shifter #(
  parameter int SIG_W = 24,
  parameter int FIX_W = 32
) (
  input  logic [SIG_W-1:0] sig_i,
  input  int               shift_i,
  output logic [FIX_W-1:0] mag_o,
  output logic             guard_o,
  output logic             sticky_o,
  output logic             ovf_o
);
  localparam int WIDE_W = SIG_W + FIX_W;

  logic [WIDE_W-1:0]  wide;
  logic [2*SIG_W-1:0] frac;
  int                 rsh;

  always_comb begin
    wide     = '0;
    frac     = '0;
    rsh      = 0;
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    ovf_o    = 1'b0;
    if (shift_i >= 0) begin
      wide  = {{FIX_W{1'b0}}, sig_i} << shift_i;
      ovf_o = (shift_i >= FIX_W);
    end else begin
      // Beyond SIG_W+1 the guard is always 0 and the leading one lands in sticky.
      rsh      = (-shift_i > SIG_W + 1) ? SIG_W + 1 : -shift_i;
      frac     = {sig_i, {SIG_W{1'b0}}} >> rsh;
      wide     = {{FIX_W{1'b0}}, frac[2*SIG_W-1:SIG_W]};
      guard_o  = frac[SIG_W-1];
      sticky_o = |frac[SIG_W-2:0];
    end
    ovf_o = ovf_o || (|wide[WIDE_W-1:FIX_W]);
    mag_o = wide[FIX_W-1:0];
  end

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// Pipelined IEEE-754 to signed fixed-point converter: capture, unpack, shift, round/saturate.
// Whole pipeline freezes while the output is held by the consumer.
module fp_to_fixed_pipe
  import fp_to_fixed_pipe_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int FIX_W  = 32,
  parameter int FRAC_W = 16
) (
  input logic               clk,
  input logic               rst,
  fp_to_fixed_pipe_if.slave bus
);
  localparam int SIG_W = MAN_W + 1;
  localparam int OP_W  = 1 + EXP_W + MAN_W;
  localparam int BIAS  = fp_bias(EXP_W);
  localparam logic [FIX_W:0] PosMax = {2'b00, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W:0] NegMag = {2'b01, {(FIX_W-1){1'b0}}};

  logic adv;
  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = adv;

  // Capture stage
  logic            s0_valid_q, s0_valid_d;
  logic [OP_W-1:0] s0_op_q, s0_op_d;
  rnd_mode_e       s0_rnd_q, s0_rnd_d;

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_op_d    = s0_op_q;
    s0_rnd_d   = s0_rnd_q;
    if (adv) begin
      s0_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s0_op_d  = bus.a;
        s0_rnd_d = rnd_mode_e'(bus.rnd_mode);
      end
    end
  end

  // S1: unpack and classify
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  fp_class_e        cls_c;
  logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  fp_class_e        s1_cls_q, s1_cls_d;
  rnd_mode_e        s1_rnd_q, s1_rnd_d;
  logic [SIG_W-1:0] s1_sig_q, s1_sig_d;
  int               s1_shift_q, s1_shift_d;

  always_comb begin
    exp_f = s0_op_q[OP_W-2 -: EXP_W];
    man_f = s0_op_q[MAN_W-1:0];
    if (exp_f == '0)       cls_c = (man_f == '0) ? ClsZero : ClsSub;
    else if (&exp_f)       cls_c = (man_f == '0) ? ClsInf : ClsNan;
    else                   cls_c = ClsNorm;

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_rnd_d   = s1_rnd_q;
    s1_sig_d   = s1_sig_q;
    s1_shift_d = s1_shift_q;
    if (adv) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        s1_sign_d  = s0_op_q[OP_W-1];
        s1_cls_d   = cls_c;
        s1_rnd_d   = s0_rnd_q;
        s1_sig_d   = {1'b1, man_f};
        s1_shift_d = int'(exp_f) - BIAS + FRAC_W - MAN_W;
      end
    end
  end

  // S2: align
  logic [FIX_W-1:0] sh_mag;
  logic             sh_guard, sh_sticky, sh_ovf;

  fp_fix_shifter #(
    .SIG_W (SIG_W),
    .FIX_W (FIX_W)
  ) u_shifter (
    .sig_i    (s1_sig_q),
    .shift_i  (s1_shift_q),
    .mag_o    (sh_mag),
    .guard_o  (sh_guard),
    .sticky_o (sh_sticky),
    .ovf_o    (sh_ovf)
  );

  logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  fp_class_e        s2_cls_q, s2_cls_d;
  rnd_mode_e        s2_rnd_q, s2_rnd_d;
  logic [FIX_W-1:0] s2_mag_q, s2_mag_d;
  logic             s2_guard_q, s2_guard_d, s2_sticky_q, s2_sticky_d, s2_ovf_q, s2_ovf_d;

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_d    = s2_cls_q;
    s2_rnd_d    = s2_rnd_q;
    s2_mag_d    = s2_mag_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    s2_ovf_d    = s2_ovf_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d   = s1_sign_q;
        s2_cls_d    = s1_cls_q;
        s2_rnd_d    = s1_rnd_q;
        s2_mag_d    = sh_mag;
        s2_guard_d  = sh_guard;
        s2_sticky_d = sh_sticky;
        s2_ovf_d    = sh_ovf;
      end
    end
  end

  // S3: round magnitude, range-check, apply sign
  logic             inc_c, over_c, ovf_c, inv_c, inx_c;
  logic [FIX_W:0]   rmag_c;
  logic [FIX_W-1:0] sat_c, res_c;
  logic             out_valid_q, out_valid_d;
  logic [FIX_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d, inv_q, inv_d, inx_q, inx_d;

  always_comb begin
    inc_c  = (s2_rnd_q == RndRne) && s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
    rmag_c = {1'b0, s2_mag_q} + {{FIX_W{1'b0}}, inc_c};
    over_c = s2_ovf_q || (s2_sign_q ? (rmag_c > NegMag) : (rmag_c > PosMax));
    sat_c  = s2_sign_q ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
    res_c  = '0;
    ovf_c  = 1'b0;
    inv_c  = 1'b0;
    inx_c  = 1'b0;
    unique case (s2_cls_q)
      ClsNan: inv_c = 1'b1;
      ClsInf: begin
        res_c = sat_c;
        ovf_c = 1'b1;
      end
      ClsSub: inx_c = 1'b1;
      ClsNorm: begin
        if (over_c) begin
          res_c = sat_c;
          ovf_c = 1'b1;
        end else begin
          res_c = s2_sign_q ? -rmag_c[FIX_W-1:0] : rmag_c[FIX_W-1:0];
          inx_c = s2_guard_q || s2_sticky_q;
        end
      end
      default: ;
    endcase

    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    inv_d       = inv_q;
    inx_d       = inx_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        result_d = res_c;
        ovf_d    = ovf_c;
        inv_d    = inv_c;
        inx_d    = inx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_op_q     <= '0;
      s0_rnd_q    <= RndRne;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= ClsZero;
      s1_rnd_q    <= RndRne;
      s1_sig_q    <= '0;
      s1_shift_q  <= 0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= ClsZero;
      s2_rnd_q    <= RndRne;
      s2_mag_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_ovf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_op_q     <= s0_op_d;
      s0_rnd_q    <= s0_rnd_d;
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_sig_q    <= s1_sig_d;
      s1_shift_q  <= s1_shift_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_rnd_q    <= s2_rnd_d;
      s2_mag_q    <= s2_mag_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      s2_ovf_q    <= s2_ovf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      inv_q       <= inv_d;
      inx_q       <= inx_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_ovf  = ovf_q;
  assign bus.flag_inv  = inv_q;
  assign bus.flag_inx  = inx_q;

endmodule

// File: doc/fp_to_fixed_pipe.md
Name: fp_to_fixed_pipe

Overview:
- Pipelined, parametrised float-to-fixed converter; successor to the combinational single-precision converter.
- Converts an IEEE-754 binary operand (configurable exponent/mantissa width) to signed two's-complement fixed point with configurable integer/fraction split.
- Adds a per-transaction rounding mode, saturation, exception flags and a valid/ready stream handshake.
- Sits between the FPU register/operand path and fixed-point datapath consumers.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (implicit bit excluded).
- FIX_W, 32, fixed-point result width (signed).
- FRAC_W, 16, fractional bits of result; legal range 0..FIX_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept operand.
- a  in  1+EXP_W+MAN_W  floating-point operand {sign, exp, man}.
- rnd_mode  in  1  0 = round-to-nearest-even, 1 = truncate toward zero; sampled with a.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  FIX_W  fixed-point result.
- flag_ovf  out  1  result saturated (overflow or infinity).
- flag_inv  out  1  NaN input.
- flag_inx  out  1  result inexact (nonzero bits discarded).

Behaviour:
- Reset: asynchronous, active-high. Clears all stage valids, out_valid=0, result=0, all flags=0. Reset mid-operation discards every in-flight operand; no output appears for those operands.
- Pipeline stages:
  - S1: unpack; classify zero/subnormal/normal/inf/NaN; compute shift = exp - bias + FRAC_W - MAN_W.
  - S2: barrel shift of {1,man}; capture guard and sticky bits; detect magnitude overflow when the left shift exceeds the available width.
  - S3: round, negate if sign, saturate, form flags.
- Latency is 3 cycles from the in_valid&&in_ready edge to out_valid, with no stall. Throughput is 1 per cycle.
- Handshake: stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalled, all stages hold their contents, and result and flags stay stable. A transfer occurs on valid&&ready at the rising edge. Bubbles collapse: empty stages advance even when a later stage holds data, provided there is no stall.
- Arithmetic: value = (-1)^s * 1.man * 2^(exp-bias). Result = round(value * 2^FRAC_W), then range-checked against [-2^(FIX_W-1), 2^(FIX_W-1)-1].
- Rounding:
  - RNE: increment when guard && (sticky || lsb).
  - Truncate: discard bits on the magnitude, i.e. toward zero for both signs.
  - Rounding is applied to the magnitude before negation.
  - A rounding carry that pushes the magnitude out of range saturates.
- Saturation:
  - Positive overflow gives 2^(FIX_W-1)-1 with flag_ovf=1.
  - Negative overflow gives -2^(FIX_W-1) with flag_ovf=1.
  - Exactly -2^(FIX_W-1) is representable: no overflow flag.
- Special inputs:
  - ±0 gives 0 with no flags.
  - Subnormals are flushed: result 0; flag_inx=1 if man≠0.
  - ±inf saturates to the signed limit with flag_ovf=1.
  - NaN gives 0 with flag_inv=1; ovf and inx are 0.
- flag_inx=1 when guard|sticky is set (after the shift), excluding the NaN case. flag_inx is forced 0 when flag_ovf=1.
- Flags are valid only when out_valid=1, and are registered with result.

Decomposition:
- Shared include file fp_fix_defs.vh holds:
  - bias computation, BIAS = 2^(EXP_W-1)-1;
  - class encodings (ZERO, SUB, NORM, INF, NAN);
  - rounding-mode encodings RND_RNE=0, RND_RTZ=1.
- One sub-module, fp_fix_shifter: combinational barrel shifter producing shifted magnitude, guard, sticky and overflow. It is instantiated in S2.
- Pipeline control, rounding and saturation stay in the top module.

Test Plan (defaults, Q16.16):
- 0x404CCCCC (≈3.2), RNE -> result 0x00033333, inx=1, out_valid exactly 3 cycles after accept.
- 0xBF000000 (-0.5) -> 0xFFFF8000, no flags. 0x42C80000 (100.0) -> 0x00640000, no flags.
- 0x37000000 (0.5 LSB), RNE -> 0x00000000, inx=1. 0x37C00000 (1.5 LSB), RNE -> 0x00000002. 0xB7C00000, RTZ -> 0xFFFFFFFF, inx=1.
- 0x47000000 (32768.0) -> 0x7FFFFFFF, ovf=1. 0xC7000000 -> 0x80000000, no flags. 0xFF800000 (-inf) -> 0x80000000, ovf=1. 0x7FC00000 -> 0x00000000, inv=1.
- Back-to-back stream of 8 operands with out_ready toggled 0/1 randomly -> no loss or duplication, in-order results. result is stable while out_valid && !out_ready, and in_ready is low during a stall.
- Assert rst with 3 operands in flight -> out_valid=0 and result=0 immediately (asynchronous). After release, a new operand produces exactly one result 3 cycles later.
